// File: rtl/regfile_mp.sv
// Multi-port register file: NWR write ports with highest-index-wins resolution,
// NRD combinational read ports with optional same-cycle write forwarding,
// optional hardwired-zero register 0, and a registered write-conflict monitor.
module regfile_mp #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NWR-1:0]                    we,
    input  logic [NWR*$clog2(DEPTH)-1:0]      waddr,
    input  logic [NWR*DATA_W-1:0]             wdata,
    input  logic [NRD*$clog2(DEPTH)-1:0]      raddr,
    output logic [NRD*DATA_W-1:0]             rdata,
    output logic                              wr_conflict,
    output logic [7:0]                        conflict_cnt
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = 8;

    typedef logic [DATA_W-1:0] word_t;

    word_t            mem_q [DEPTH];
    word_t            mem_d [DEPTH];
    logic             wr_conflict_q;
    logic             wr_conflict_d;
    logic [CNT_W-1:0] conflict_cnt_q;
    logic [CNT_W-1:0] conflict_cnt_d;
    logic             conflict_c;

    // Next register contents: ascending port order so the highest enabled port wins.
    always_comb begin
        logic [AW-1:0] wa;
        wa = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            mem_d[k] = mem_q[k];
        end
        for (int unsigned i = 0; i < NWR; i++) begin
            wa = waddr[i*AW +: AW];
            if (we[i] && !(ZERO_REG && (wa == '0))) begin
                mem_d[wa] = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Conflict detection: any pair of enabled ports on the same writable address.
    always_comb begin
        logic [AW-1:0] wa_i;
        logic [AW-1:0] wa_j;
        conflict_c = 1'b0;
        wa_i       = '0;
        wa_j       = '0;
        for (int unsigned i = 0; i < NWR; i++) begin
            for (int unsigned j = i + 1; j < NWR; j++) begin
                wa_i = waddr[i*AW +: AW];
                wa_j = waddr[j*AW +: AW];
                if (we[i] && we[j] && (wa_i == wa_j) && !(ZERO_REG && (wa_i == '0))) begin
                    conflict_c = 1'b1;
                end
            end
        end
    end

    // Conflict flag and saturating conflict counter next-state.
    always_comb begin
        wr_conflict_d  = conflict_c;
        conflict_cnt_d = conflict_cnt_q;
        if (conflict_c && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    // Read ports: forwarded view (mem_d) only when bypass is on and not in reset.
    always_comb begin
        logic [AW-1:0] ra;
        word_t         rd;
        rdata = '0;
        ra    = '0;
        rd    = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
            ra = raddr[j*AW +: AW];
            rd = (BYPASS && reset) ? mem_d[ra] : mem_q[ra];
            if (ZERO_REG && (ra == '0)) begin
                rd = '0;
            end
            rdata[j*DATA_W +: DATA_W] = rd;
        end
    end

    // State registers with synchronous active-low clear that overrides writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            wr_conflict_q  <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k] <= mem_d[k];
            end
            wr_conflict_q  <= wr_conflict_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign wr_conflict  = wr_conflict_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default instance plus a BYPASS=0/ZERO_REG=0 instance
// driven in parallel and compared against an array-based reference model.
module tb_regfile_mp;

    logic        clk;
    logic        reset;
    logic [1:0]  we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  raddr;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        conf_a;
    logic        conf_b;
    logic [7:0]  cnt_a;
    logic [7:0]  cnt_b;

    int total;
    int bad;

    // Reference model: index 0 = default config, index 1 = no bypass / no zero reg.
    logic [15:0] mdl [2][16];
    bit          cfg_zero [2];
    bit          cfg_byp  [2];
    bit          exp_conf [2];
    int          exp_cnt  [2];

    regfile_mp dut_a (
        .clk          (clk),
        .reset        (reset),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .raddr        (raddr),
        .rdata        (rdata_a),
        .wr_conflict  (conf_a),
        .conflict_cnt (cnt_a)
    );

    regfile_mp #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .raddr        (raddr),
        .rdata        (rdata_b),
        .wr_conflict  (conf_b),
        .conflict_cnt (cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // Highest-index enabled port writing address a, or -1.
    function automatic int winner(int a);
        for (int i = 1; i >= 0; i--) begin
            if (we[i] && (32'(waddr[i*4 +: 4]) == a)) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] exp_rd(int c, int a);
        int w;
        if (cfg_zero[c] && a == 0) return 16'h0000;
        if (cfg_byp[c] && reset) begin
            w = winner(a);
            if (w >= 0) return wdata[w*16 +: 16];
        end
        return mdl[c][a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model update at the clock edge, from the spec's rules.
    task automatic commit();
        int n;
        int w;
        bit hit;
        for (int c = 0; c < 2; c++) begin
            if (!reset) begin
                for (int a = 0; a < 16; a++) mdl[c][a] = 16'h0000;
                exp_conf[c] = 1'b0;
                exp_cnt[c]  = 0;
            end else begin
                hit = 1'b0;
                for (int a = 0; a < 16; a++) begin
                    if (cfg_zero[c] && a == 0) continue;
                    n = 0;
                    for (int p = 0; p < 2; p++) begin
                        if (we[p] && (32'(waddr[p*4 +: 4]) == a)) n++;
                    end
                    if (n >= 2) hit = 1'b1;
                    w = winner(a);
                    if (w >= 0) mdl[c][a] = wdata[w*16 +: 16];
                end
                exp_conf[c] = hit;
                if (hit && exp_cnt[c] < 255) exp_cnt[c]++;
            end
        end
    endtask

    // One clock: check pre-edge outputs, advance model at the edge, return at negedge.
    task automatic cycle(input bit do_chk);
        #1;
        if (do_chk) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("a_rdata%0d@r%0d", p, raddr[p*4 +: 4]),
                      32'(rdata_a[p*16 +: 16]), 32'(exp_rd(0, 32'(raddr[p*4 +: 4]))));
                check($sformatf("b_rdata%0d@r%0d", p, raddr[p*4 +: 4]),
                      32'(rdata_b[p*16 +: 16]), 32'(exp_rd(1, 32'(raddr[p*4 +: 4]))));
            end
            check("a_wr_conflict",  32'(conf_a), 32'(exp_conf[0]));
            check("b_wr_conflict",  32'(conf_b), 32'(exp_conf[1]));
            check("a_conflict_cnt", 32'(cnt_a),  32'(exp_cnt[0]));
            check("b_conflict_cnt", 32'(cnt_b),  32'(exp_cnt[1]));
        end
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] w, input int a0, input int d0,
                         input int a1, input int d1, input int r0, input int r1);
        we    = w;
        waddr = {4'(a1), 4'(a0)};
        wdata = {16'(d1), 16'(d0)};
        raddr = {4'(r1), 4'(r0)};
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        cfg_zero[0] = 1'b1; cfg_byp[0] = 1'b1;
        cfg_zero[1] = 1'b0; cfg_byp[1] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 16; a++) mdl[c][a] = 16'h0000;
            exp_conf[c] = 1'b0;
            exp_cnt[c]  = 0;
        end

        // Reset held two cycles; writes presented during reset must be ignored.
        reset = 1'b0;
        drive(2'b11, 9, 'h1357, 4, 'h2468, 9, 4);
        cycle(1'b0);
        cycle(1'b1);
        reset = 1'b1;

        // All addresses read back zero on both ports.
        for (int a = 0; a < 16; a++) begin
            drive(2'b00, 0, 0, 0, 0, a, 15 - a);
            cycle(1'b1);
        end

        // Distinct-address writes commit together.
        drive(2'b11, 3, 'hBEEF, 5, 'h1234, 1, 2);
        cycle(1'b1);
        drive(2'b00, 0, 0, 0, 0, 3, 5);
        cycle(1'b1);

        // Same-address conflict: port 1 wins, flag pulses one cycle.
        drive(2'b11, 7, 'hAAAA, 7, 'h5555, 7, 3);
        cycle(1'b1);
        drive(2'b00, 0, 0, 0, 0, 7, 7);
        cycle(1'b1);
        drive(2'b00, 0, 0, 0, 0, 7, 5);
        cycle(1'b1);

        // Forwarding: default instance sees new data pre-edge, the other the old value.
        drive(2'b10, 0, 0, 9, 'h0F0F, 1, 1);
        cycle(1'b1);
        drive(2'b01, 9, 'hC0DE, 0, 0, 3, 9);
        cycle(1'b1);
        drive(2'b00, 0, 0, 0, 0, 9, 9);
        cycle(1'b1);

        // Writes to r0 from both ports.
        drive(2'b11, 0, 'hFFFF, 0, 'h1111, 0, 0);
        cycle(1'b1);
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        cycle(1'b1);

        // Randomized traffic with occasional mid-run resets.
        for (int n = 0; n < 250; n++) begin
            reset = ($urandom_range(0, 39) != 0);
            drive(2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            cycle(1'b1);
        end
        reset = 1'b1;

        // Counter saturation over 300 conflicting cycles.
        for (int n = 0; n < 300; n++) begin
            drive(2'b11, 4, int'($urandom_range(0, 65535)), 4, int'($urandom_range(0, 65535)), 4, 2);
            cycle(1'b1);
        end
        drive(2'b00, 0, 0, 0, 0, 4, 2);
        cycle(1'b1);
        check("cnt_saturated", 32'(cnt_a), 32'hFF);

        // Reset beats a simultaneous write to r2.
        reset = 1'b0;
        drive(2'b01, 2, 'h7777, 0, 0, 2, 2);
        cycle(1'b1);
        reset = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 2, 2);
        cycle(1'b1);
        check("r2_after_reset", 32'(rdata_a[15:0]), 32'h0);
        cycle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
